// File: rtl/lab_entrance_pkg.sv
// lab_entrance_pkg: shared mode codes, decision-state encoding and helpers for the lab entrance controller
package lab_entrance_pkg;
  localparam logic [1:0] MODE_EXIT = 2'b00;
  localparam logic [1:0] MODE_ENTER = 2'b01;
  localparam logic [1:0] ST_IDLE_FLAGS = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_DENY_PAR = 2'd2;
  localparam logic [1:0] ST_DENY_FULL = 2'd3;
  function automatic logic is_idle(input logic [1:0] mode);
    return mode[1];
  endfunction
  // codes are zero-extended, which leaves the XOR reduction unchanged
  function automatic logic parity(input logic [31:0] code);
    return ^code;
  endfunction
endpackage

// File: rtl/lab_entrance_ctrl_if.sv
// lab_entrance_if: card-reader request and per-lab status bundle between front end and controller
interface lab_entrance_if #(
  parameter int NUM_LABS = 4,
  parameter int CODE_W = 5,
  parameter int LAB_W = 2,
  parameter int CNT_W = 5,
  parameter int DEN_W = 8
);
  logic [CODE_W-1:0] smartCode;
  logic [LAB_W-1:0] lab;
  logic [1:0] mode;
  logic clrDenied;
  logic [NUM_LABS*CNT_W-1:0] numOfStu;
  logic [NUM_LABS-1:0] restrictionWarn;
  logic [NUM_LABS-1:0] isFull;
  logic [NUM_LABS-1:0] isEmpty;
  logic [NUM_LABS-1:0] unlock;
  logic [NUM_LABS*DEN_W-1:0] deniedCnt;
  modport master (
    output smartCode, lab, mode, clrDenied,
    input numOfStu, restrictionWarn, isFull, isEmpty, unlock, deniedCnt
  );
  modport slave (
    input smartCode, lab, mode, clrDenied,
    output numOfStu, restrictionWarn, isFull, isEmpty, unlock, deniedCnt
  );
endinterface

// File: rtl/lab_entrance_ctrl_lab_slot.sv
// lab_slot: one lab's occupancy counter, decision state and saturating denied counter
module lab_slot
  import lab_entrance_pkg::*;
#(
  parameter int CAP = 30,
  parameter int RESTRICT = 15,
  parameter int CNT_W = 5,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic             enter_i,
  input  logic             par_ok_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             unlock_o,
  output logic             warn_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEN_W-1:0] den_o
);
  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] RES_C = CNT_W'(RESTRICT);
  logic [CNT_W-1:0] c_q, c_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [1:0] st_q, st_d;
  logic deny;
  always_comb begin
    st_d = !sel_i ? ST_IDLE_FLAGS :
           enter_i ? ((c_q == CAP_C) ? ST_DENY_FULL :
                      (c_q >= RES_C && !par_ok_i) ? ST_DENY_PAR : ST_ACCEPT) :
           (c_q != '0) ? ST_ACCEPT : ST_IDLE_FLAGS;
    c_d = (st_d != ST_ACCEPT) ? c_q : enter_i ? c_q + CNT_W'(1) : c_q - CNT_W'(1);
    deny = st_d == ST_DENY_PAR || st_d == ST_DENY_FULL;
    den_d = clr_i ? '0 : (deny && den_q != {DEN_W{1'b1}}) ? den_q + DEN_W'(1) : den_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      den_q <= '0;
      st_q <= ST_IDLE_FLAGS;
    end else begin
      c_q <= c_d;
      den_q <= den_d;
      st_q <= st_d;
    end
  end
  assign count_o = c_q;
  assign unlock_o = st_q == ST_ACCEPT;
  assign warn_o = st_q == ST_DENY_PAR;
  assign full_o = c_q == CAP_C;
  assign empty_o = c_q == '0;
  assign den_o = den_q;
endmodule

// File: rtl/lab_entrance_ctrl.sv
// lab_entrance_ctrl: decodes one card request per cycle and routes it to NUM_LABS lab_slot instances
module lab_entrance_ctrl
  import lab_entrance_pkg::*;
#(
  parameter int NUM_LABS = 4,
  parameter int CODE_W = 5,
  parameter int CAP = 30,
  parameter int RESTRICT = 15,
  parameter logic [NUM_LABS-1:0] ODD_MASK = NUM_LABS'(4'b0101),
  parameter int DEN_W = 8
) (
  input logic CLK,
  input logic RST,
  lab_entrance_if.slave bus
);
  localparam int LAB_W = NUM_LABS > 1 ? $clog2(NUM_LABS) : 1;
  localparam int CNT_W = $clog2(CAP + 1);
  logic active, enter, par;
  // out-of-range lab indices fall through as idle cycles
  assign active = !is_idle(bus.mode) && (int'(bus.lab) < NUM_LABS);
  assign enter = bus.mode == MODE_ENTER;
  assign par = parity(32'(bus.smartCode));
  for (genvar i = 0; i < NUM_LABS; i++) begin : g_slot
    lab_slot #(
      .CAP(CAP),
      .RESTRICT(RESTRICT),
      .CNT_W(CNT_W),
      .DEN_W(DEN_W)
    ) u_slot (
      .clk(CLK),
      .rst(RST),
      .sel_i(active && bus.lab == LAB_W'(i)),
      .enter_i(enter),
      .par_ok_i(par == ODD_MASK[i]),
      .clr_i(bus.clrDenied),
      .count_o(bus.numOfStu[i*CNT_W +: CNT_W]),
      .unlock_o(bus.unlock[i]),
      .warn_o(bus.restrictionWarn[i]),
      .full_o(bus.isFull[i]),
      .empty_o(bus.isEmpty[i]),
      .den_o(bus.deniedCnt[i*DEN_W +: DEN_W])
    );
  end
endmodule

// File: tb/tb_lab_entrance_ctrl.sv
// tb_lab_entrance_ctrl: directed checks on default, three-lab and 2-bit-denied-counter configurations
module tb_lab_entrance_ctrl;
  import lab_entrance_pkg::*;
  localparam logic [4:0] EVEN = 5'b11101;
  localparam logic [4:0] ODD = 5'b10101;
  logic CLK = 1'b0;
  logic RST;
  int n_run = 0;
  int n_fail = 0;
  always #5 CLK = ~CLK;
  lab_entrance_if #(.NUM_LABS(4), .CODE_W(5), .LAB_W(2), .CNT_W(5), .DEN_W(8)) ifa ();
  lab_entrance_if #(.NUM_LABS(3), .CODE_W(5), .LAB_W(2), .CNT_W(5), .DEN_W(8)) ifb ();
  lab_entrance_if #(.NUM_LABS(4), .CODE_W(5), .LAB_W(2), .CNT_W(5), .DEN_W(2)) ifc ();
  lab_entrance_ctrl u_a (.CLK(CLK), .RST(RST), .bus(ifa));
  lab_entrance_ctrl #(.NUM_LABS(3), .ODD_MASK(3'b101)) u_b (.CLK(CLK), .RST(RST), .bus(ifb));
  lab_entrance_ctrl #(.DEN_W(2)) u_c (.CLK(CLK), .RST(RST), .bus(ifc));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_all();
    ifa.mode = 2'b10; ifa.lab = '0; ifa.smartCode = '0; ifa.clrDenied = 1'b0;
    ifb.mode = 2'b10; ifb.lab = '0; ifb.smartCode = '0; ifb.clrDenied = 1'b0;
    ifc.mode = 2'b10; ifc.lab = '0; ifc.smartCode = '0; ifc.clrDenied = 1'b0;
  endtask
  task automatic req_a(input logic [1:0] m, input logic [1:0] l, input logic [4:0] code);
    ifa.mode = m; ifa.lab = l; ifa.smartCode = code;
  endtask
  function automatic logic [4:0] cnt_a(input int i);
    return ifa.numOfStu[i*5 +: 5];
  endfunction
  function automatic logic [7:0] den_a(input int i);
    return ifa.deniedCnt[i*8 +: 8];
  endfunction
  initial begin
    idle_all();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    check("rst_cnt", ifa.numOfStu, 0);
    check("rst_empty", ifa.isEmpty, 4'hf);
    check("rst_full", ifa.isFull, 0);
    check("rst_unlock", ifa.unlock, 0);
    check("rst_warn", ifa.restrictionWarn, 0);
    check("rst_den", ifa.deniedCnt, 0);
    req_a(MODE_ENTER, 2'd0, EVEN);
    for (int k = 0; k < 5; k++) step();
    check("mid_cnt5", cnt_a(0), 5);
    check("mid_unlock", ifa.unlock, 4'b0001);
    check("mid_empty", ifa.isEmpty, 4'b1110);
    RST = 1'b1;
    step();
    RST = 1'b0;
    req_a(2'b10, 2'd0, EVEN);
    check("mrst_cnt", ifa.numOfStu, 0);
    check("mrst_empty", ifa.isEmpty, 4'hf);
    check("mrst_unlock", ifa.unlock, 0);
    check("mrst_den", ifa.deniedCnt, 0);
    step();
    check("idle_cnt", ifa.numOfStu, 0);
    req_a(MODE_ENTER, 2'd0, EVEN);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("res_c14_warn", ifa.restrictionWarn[0], 0);
      if (k == 15) begin
        check("res_c15_cnt", cnt_a(0), 15);
        check("res_c15_unlock", ifa.unlock[0], 1);
      end
      if (k == 16) begin
        check("res_c16_warn", ifa.restrictionWarn[0], 1);
        check("res_c16_unlock", ifa.unlock[0], 0);
      end
    end
    check("res_cnt", cnt_a(0), 15);
    check("res_warn", ifa.restrictionWarn, 4'b0001);
    check("res_den", den_a(0), 5);
    check("res_full", ifa.isFull, 0);
    req_a(MODE_EXIT, 2'd0, EVEN);
    step();
    check("rel_cnt", cnt_a(0), 14);
    check("rel_warn", ifa.restrictionWarn[0], 0);
    check("rel_unlock", ifa.unlock[0], 1);
    req_a(MODE_ENTER, 2'd0, EVEN);
    step();
    check("rel_re_cnt", cnt_a(0), 15);
    check("rel_re_unlock", ifa.unlock[0], 1);
    step();
    check("rel_deny_warn", ifa.restrictionWarn[0], 1);
    check("rel_deny_den", den_a(0), 6);
    req_a(MODE_ENTER, 2'd0, ODD);
    step();
    check("odd_cnt", cnt_a(0), 16);
    check("odd_unlock", ifa.unlock, 4'b0001);
    req_a(MODE_ENTER, 2'd1, EVEN);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 30) check("full_k30_unlock", ifa.unlock[1], 1);
      if (k >= 31) begin
        check("full_tail_unlock", ifa.unlock[1], 0);
        check("full_tail_warn", ifa.restrictionWarn[1], 0);
      end
    end
    check("full_cnt", cnt_a(1), 30);
    check("full_flag", ifa.isFull, 4'b0010);
    check("full_den", den_a(1), 2);
    check("full_lab0", cnt_a(0), 16);
    req_a(MODE_ENTER, 2'd1, ODD);
    step();
    check("full_odd_warn", ifa.restrictionWarn, 0);
    check("full_odd_den", den_a(1), 3);
    req_a(MODE_EXIT, 2'd2, EVEN);
    step();
    check("empty_unlock", ifa.unlock, 0);
    check("empty_cnt", cnt_a(2), 0);
    check("empty_flag", ifa.isEmpty[2], 1);
    check("empty_den", den_a(2), 0);
    req_a(MODE_EXIT, 2'd1, EVEN);
    step();
    check("exit1_cnt", cnt_a(1), 29);
    check("exit1_unlock", ifa.unlock, 4'b0010);
    check("exit1_full", ifa.isFull, 0);
    req_a(2'b11, 2'd0, ODD);
    step();
    check("idle11_cnt", cnt_a(0), 16);
    check("idle11_unlock", ifa.unlock, 0);
    ifa.clrDenied = 1'b1;
    req_a(2'b10, 2'd0, EVEN);
    step();
    ifa.clrDenied = 1'b0;
    check("clr_den", ifa.deniedCnt, 0);
    check("clr_keep_cnt", cnt_a(1), 29);
    ifb.mode = MODE_ENTER; ifb.lab = 2'd3; ifb.smartCode = EVEN;
    step();
    step();
    check("oor_cnt", ifb.numOfStu, 0);
    check("oor_unlock", ifb.unlock, 0);
    check("oor_den", ifb.deniedCnt, 0);
    ifb.lab = 2'd2;
    step();
    check("b_lab2_cnt", ifb.numOfStu, 15'd1 << 10);
    check("b_lab2_unlock", ifb.unlock, 3'b100);
    ifb.mode = 2'b10;
    ifc.mode = MODE_ENTER; ifc.lab = 2'd3; ifc.smartCode = EVEN;
    for (int k = 0; k < 30; k++) step();
    check("sat_full", ifc.isFull, 4'b1000);
    for (int k = 0; k < 5; k++) step();
    check("sat_den", ifc.deniedCnt[7:6], 3);
    check("sat_cnt", ifc.numOfStu[19:15], 30);
    ifc.clrDenied = 1'b1;
    step();
    check("sat_clr_wins", ifc.deniedCnt[7:6], 0);
    ifc.clrDenied = 1'b0;
    step();
    check("sat_after_clr", ifc.deniedCnt[7:6], 1);
    idle_all();
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
